// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: a single pipeline register stage with a 2-entry skid buffer.
// It carries an opaque payload over a valid/ready handshake.
//
// Handshake: a payload moves on a clock edge when valid && ready are both high.
//   - in_ready and out_valid come from registers only, so there is no
//     combinational path from the input side to the output side.
//   - The exception is reset, which forces in_ready low while it is asserted.
//   - While flush is high, nothing is accepted or delivered, whatever the
//     handshake signals show.
//
// The state register doubles as the debug/occupancy output (EMPTY=0, ONE=1, FULL=2).
//
// Optional feature, macro PIPE_STAGE_STATS_EN:
//   - Defined: stall_cnt and flush_cnt are saturating counters.
//   - Undefined: both ports are tied to zero and no counter flops exist.
module pipe_stage_skid #(
    parameter int PAYLOAD_WIDTH = 175,
    parameter int STAT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [STAT_WIDTH-1:0]    stall_cnt,
    output logic [STAT_WIDTH-1:0]    flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
    logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
    logic                     acc;
    logic                     pop;

    assign in_ready  = (state_q != FULL) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state and data movement.
    // Main always holds the oldest entry, and skid holds the second one.
    // Empty registers are driven to zero so out_data reads 0 when nothing is held.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (acc && pop) begin
                        main_d = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State and payload registers; reset discards everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters.
    // A stall is a presented payload held back by the consumer.
    // A flush only counts when it actually kills an entry.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != STAT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (state_q != EMPTY) && (flush_cnt_q != STAT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers clear only on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid.
// - A queue-based FIFO model (capacity 2) predicts every output on each falling edge.
// - Hand-computed literal checks pin the directed scenarios.
// - Delivered payloads are collected from the DUT side and compared against
//   literal sequences.
module tb_pipe_stage_skid;

    localparam int PW   = 175;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;
`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] flush_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // model state: FIFO contents plus raw event counts
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int            m_stall = 0;
    int            m_flush = 0;

    pipe_stage_skid #(.PAYLOAD_WIDTH(PW), .STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    // Behavioural model: a 2-deep FIFO evaluated at each rising edge.
    always @(posedge clk or posedge reset) begin
        bit do_pop;
        bit do_acc;
        if (reset) begin
            exp_q.delete();
            m_stall = 0;
            m_flush = 0;
        end else if (flush) begin
            if (exp_q.size() > 0) m_flush++;
            exp_q.delete();
        end else begin
            do_acc = in_valid && (exp_q.size() < 2);
            do_pop = out_ready && (exp_q.size() > 0);
            if ((exp_q.size() > 0) && !out_ready) m_stall++;
            if (do_pop) void'(exp_q.pop_front());
            if (do_acc) exp_q.push_back(in_data);
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [PW-1:0] e_data;
        e_data = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("cyc_in_ready", in_ready, (exp_q.size() < 2) && !reset);
        check("cyc_out_valid", out_valid, exp_q.size() > 0);
        check("cyc_out_data", out_data, e_data);
        check("cyc_occupancy", occupancy, exp_q.size());
        check("cyc_stall_cnt", stall_cnt, STATS ? sat(m_stall) : 0);
        check("cyc_flush_cnt", flush_cnt, STATS ? sat(m_flush) : 0);
    end

    // Driver.
    // - Applies inputs away from the clock edges.
    // - Logs the payload the DUT delivers on the coming edge.
    // - Then advances one clock.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [PW-1:0] id, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        if (out_valid && out_ready && !flush && !reset) got_q.push_back(out_data);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 reset = 1'b1;
        @(posedge clk); #2;

        // reset with a pending producer
        step(1, 0, 1, 'hAB, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        step(0, 0, 0, 0, 0);
        check("rst_release_in_ready", in_ready, 1);

        // streaming
        got_q.delete();
        step(0, 0, 1, 'h1, 1);
        check("str_data1", out_data, 'h1);
        check("str_occ1", occupancy, 1);
        step(0, 0, 1, 'h2, 1);
        check("str_data2", out_data, 'h2);
        check("str_ready2", in_ready, 1);
        step(0, 0, 1, 'h3, 1);
        check("str_data3", out_data, 'h3);
        check("str_occ3", occupancy, 1);
        step(0, 0, 0, 'h99, 1);
        check("str_drain_occ", occupancy, 0);
        check("str_got_n", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) check("str_got", got_q[i], i + 1);

        // back-pressure
        got_q.delete();
        step(0, 0, 1, 'h10, 0);
        step(0, 0, 1, 'h20, 0);
        check("bp_occ", occupancy, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_data", out_data, 'h10);
        step(0, 0, 1, 'h30, 1);
        check("bp_pop1_data", out_data, 'h20);
        check("bp_pop1_occ", occupancy, 1);
        step(0, 0, 0, 0, 1);
        check("bp_empty_occ", occupancy, 0);
        check("bp_empty_data", out_data, 0);
        check("bp_skid_clear", dut.skid_q, 0);
        check("bp_got_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("bp_got0", got_q[0], 'h10);
            check("bp_got1", got_q[1], 'h20);
        end

        // simultaneous accept and pop in ONE
        got_q.delete();
        step(0, 0, 1, 'h5, 0);
        step(0, 0, 1, 'h6, 1);
        check("sim_occ", occupancy, 1);
        check("sim_data", out_data, 'h6);
        step(0, 0, 0, 0, 1);
        check("sim_got_n", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("sim_got0", got_q[0], 'h5);
            check("sim_got1", got_q[1], 'h6);
        end

        // flush while full, with a producer and a consumer both active
        got_q.delete();
        step(0, 0, 1, 'hA1, 0);
        step(0, 0, 1, 'hA2, 0);
        check("fl_pre_occ", occupancy, 2);
        step(0, 1, 1, 'hA3, 1);
        check("fl_occ", occupancy, 0);
        check("fl_data", out_data, 0);
        check("fl_got_n", got_q.size(), 0);
        check("fl_cnt", flush_cnt, STATS ? 1 : 0);
        step(0, 1, 0, 0, 0);
        check("fl_empty_cnt", flush_cnt, STATS ? 1 : 0);

        // stall counter saturation
        step(0, 0, 1, 'h77, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 'h55, 0);
        check("sat_stall_cnt", stall_cnt, STATS ? SMAX : 0);
        check("sat_hold_data", out_data, 'h77);

        // reset in the middle of a transfer
        step(0, 0, 1, 'h33, 1);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_stall_cnt", stall_cnt, 0);
        step(1, 0, 1, 'h44, 1);
        step(0, 0, 0, 0, 1);
        check("midrst_occ", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, generalised replacement for the fixed-field decode/execute pipeline registers. Carries one opaque payload bus between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer lets back-pressure from the consumer stall the producer without combinational ready paths. Flush (branch mispredict/jump kill) empties the stage, and all data registers read zero when the stage holds nothing.

Parameters:
PAYLOAD_WIDTH, 175, payload bits: RD1, RD2, PC, ExtImm and PCPlus4 at 32 bits each, plus Rs1, Rs2 and Rd at 5 bits each.
STAT_WIDTH, 16, width of statistics counters (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all stage contents
in_valid  in  1  producer has payload
in_ready  out  1  stage can accept payload
in_data  in  PAYLOAD_WIDTH  producer payload
out_valid  out  1  stage presents payload
out_ready  in  1  consumer accepts payload
out_data  out  PAYLOAD_WIDTH  payload to consumer
occupancy  out  2  entries held (0..2)
stall_cnt  out  STAT_WIDTH  cycles with out_valid=1 and out_ready=0
flush_cnt  out  STAT_WIDTH  flushes that killed ≥1 entry

Behaviour:
- Storage: main register (drives out_data), skid register, and a state register: EMPTY=0, ONE=1, FULL=2. occupancy equals the state encoding.
- in_ready = (state != FULL) && !reset.
- out_valid = (state != EMPTY).
- Both in_ready and out_valid derive from registers only. There is no in-to-out combinational path.
- acc = in_valid && in_ready; pop = out_valid && out_ready.
- Reset (async): state=EMPTY, main=0, skid=0, counters=0. While reset is high: in_ready=0, out_valid=0, out_data=0. Reset mid-transfer discards all contents.
- flush (sync, highest priority after reset): next state=EMPTY, main<=0, skid<=0. Any acc or pop in the same cycle is ignored; the consumer must not treat that cycle's payload as delivered.
- State transitions when flush=0:
  - EMPTY: acc -> ONE, main<=in_data. No acc -> stay.
  - ONE: acc & !pop -> FULL, skid<=in_data. acc & pop -> ONE, main<=in_data. !acc & pop -> EMPTY, main<=0. Neither -> hold.
  - FULL: pop -> ONE, main<=skid, skid<=0. No pop -> hold. acc is impossible because in_ready=0.
- Latency: payload accepted at edge N appears on out_data after edge N, i.e. one cycle, when the stage is not back-pressured.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by flush or reset.
- Full throughput: 1 transfer/cycle sustained while out_ready=1.
- Invariant: out_data==0 whenever out_valid==0. Skid is 0 whenever state!=FULL.
- in_data is sampled only on acc. in_data changes without acc have no effect.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid && !out_ready && !flush.
  - flush_cnt increments on each flush cycle with state!=EMPTY.
  - Both saturate at 2^STAT_WIDTH-1 and clear only on reset.
- Not defined: stall_cnt and flush_cnt are constant 0, no counter flops are synthesised, and the ports remain present.

Test Plan:
- Reset: assert reset with in_valid=1, in_data=0xAB -> in_ready=0, out_valid=0, out_data=0, occupancy=0. Deassert -> in_ready=1 at next cycle.
- Streaming: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, occupancy stays 1, zero bubbles.
- Back-pressure: out_ready=0, push 0x10,0x20 -> occupancy=2, in_ready=0, out_data=0x10. Raise out_ready -> 0x10, then 0x20 delivered. Skid reads 0 after drain, occupancy returns to 0, out_data=0.
- Simultaneous in ONE: state ONE holding 0x5, acc 0x6 and pop the same cycle -> state ONE, out_data=0x6, 0x5 delivered exactly once.
- Flush in FULL with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_data=0, neither payload delivered. With PIPE_STAGE_STATS_EN: flush_cnt=1.
- Stats saturation (STAT_WIDTH=4, macro defined): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Without macro -> stall_cnt=0 throughout.
